// File: rtl/led_pwm_dimmer.sv
// led_pwm_dimmer: Avalon-MM slave that dims the LED PIO pattern with global
// PWM brightness, an optional blink gate and output polarity control.
// Optional feature macro: LED_PWM_BLINK_EN (BLINK register + blink gate).
module led_pwm_dimmer #(
  parameter int unsigned PRESCALE = 195
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [7:0]  led_in,
  output logic [7:0]  led_out
);

  localparam int unsigned PW = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned BW = 16;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [DW-1:0] DUTY_FULL = {DW{1'b1}};

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_DUTY   = 2'd1;
  localparam logic [1:0] ADDR_BLINK  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  logic [1:0]    ctrl_q, ctrl_d;
  logic [DW-1:0] duty_q, duty_d;
  logic [DW-1:0] duty_act_q, duty_act_d;
  logic [DW-1:0] led_q, led_d;
  logic [DW-1:0] led_out_q, led_out_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [DW-1:0] pwm_q, pwm_d;

  logic wr_c, en_c, inv_c, tick_c, wrap_c, pwm_on_c, blink_phase_c, gate_c;

  assign wr_c     = chipselect && !write_n;
  assign en_c     = ctrl_q[0];
  assign inv_c    = ctrl_q[1];
  assign tick_c   = en_c && (presc_q == PRESC_MAX);
  assign wrap_c   = tick_c && (pwm_q == DUTY_FULL);
  assign pwm_on_c = (duty_act_q == DUTY_FULL) || (pwm_q < duty_act_q);
  assign gate_c   = pwm_on_c & blink_phase_c;
  assign led_out  = led_out_q;

`ifdef LED_PWM_BLINK_EN
  logic [BW-1:0] blink_q, blink_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;
  logic          unused_c;

  assign unused_c      = ^writedata[31:16];
  assign blink_phase_c = blink_phase_q;

  // Blink register and half-period counter; a BLINK write restarts the gate
  always_comb begin
    blink_d       = blink_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (wr_c && (address == ADDR_BLINK)) begin
      blink_d = writedata[BW-1:0];
    end
    if (!en_c || (blink_q == '0) || (wr_c && (address == ADDR_BLINK))) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b1;
    end else if (wrap_c) begin
      if (blink_cnt_q == blink_q - BW'(1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  // Blink state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_q       <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
    end else begin
      blink_q       <= blink_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end
`else
  logic unused_c;

  assign unused_c      = ^writedata[31:8];
  assign blink_phase_c = 1'b1;
`endif

  // Bus registers, prescaler, PWM counter, duty shadow and output next-state
  always_comb begin
    ctrl_d     = ctrl_q;
    duty_d     = duty_q;
    duty_act_d = duty_act_q;
    presc_d    = presc_q;
    pwm_d      = pwm_q;
    led_d      = led_in;
    led_out_d  = led_q ^ {DW{inv_c}};

    if (wr_c && (address == ADDR_CTRL)) begin
      ctrl_d = writedata[1:0];
    end
    if (wr_c && (address == ADDR_DUTY)) begin
      duty_d = writedata[DW-1:0];
    end

    if (!en_c) begin
      presc_d    = '0;
      pwm_d      = '0;
      duty_act_d = duty_q;
    end else begin
      presc_d = tick_c ? '0 : presc_q + PW'(1);
      pwm_d   = tick_c ? pwm_q + DW'(1) : pwm_q;
      if (wrap_c) begin
        duty_act_d = duty_q;
      end
      led_out_d = (led_q & {DW{gate_c}}) ^ {DW{inv_c}};
    end
  end

  // State registers; led_out clears asynchronously on reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q     <= '0;
      duty_q     <= DUTY_FULL;
      duty_act_q <= DUTY_FULL;
      presc_q    <= '0;
      pwm_q      <= '0;
      led_q      <= '0;
      led_out_q  <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      duty_q     <= duty_d;
      duty_act_q <= duty_act_d;
      presc_q    <= presc_d;
      pwm_q      <= pwm_d;
      led_q      <= led_d;
      led_out_q  <= led_out_d;
    end
  end

  // Zero-wait-state read mux
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL:   readdata = {30'b0, ctrl_q};
      ADDR_DUTY:   readdata = {24'b0, duty_q};
`ifdef LED_PWM_BLINK_EN
      ADDR_BLINK:  readdata = {16'b0, blink_q};
`else
      ADDR_BLINK:  readdata = '0;
`endif
      ADDR_STATUS: readdata = {23'b0, blink_phase_c, pwm_q};
      default:     readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_led_pwm_dimmer.sv
// Self-checking bench for led_pwm_dimmer: randomized bus/LED stimulus, a
// time-based reference model feeding a scoreboard queue, and a monitor.
module tb_led_pwm_dimmer;

  localparam int unsigned P = 2;
  localparam int unsigned PERIOD = 256 * P;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  led_in = '0;
  logic [7:0]  led_out;

  int checks = 0;
  int failures = 0;

  led_pwm_dimmer #(.PRESCALE(P)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .led_in     (led_in),
    .led_out    (led_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: register images plus elapsed time since EN went active
  logic [1:0]  m_ctrl;
  logic [7:0]  m_duty, m_dact, m_led;
  logic [15:0] m_blink;
  longint      m_k, m_w;
  logic [7:0]  exp_q[$];

  function automatic logic [7:0] m_pwm();
    return 8'((m_k / P) % 256);
  endfunction

  function automatic logic m_phase();
    if (m_blink == 16'd0) return 1'b1;
    return ((m_w / m_blink) % 2) == 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0: return {30'b0, m_ctrl};
      2'd1: return {24'b0, m_duty};
`ifdef LED_PWM_BLINK_EN
      2'd2: return {16'b0, m_blink};
`else
      2'd2: return 32'd0;
`endif
      default: return {23'b0, m_phase(), m_pwm()};
    endcase
  endfunction

  initial begin
    logic       on_m, wrap_m, bw_m, we_m;
    logic [7:0] e;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_ctrl = 2'd0; m_duty = 8'hFF; m_dact = 8'hFF; m_blink = 16'd0;
        m_led = 8'd0; m_k = 0; m_w = 0;
        exp_q.delete();
      end else begin
        on_m = (m_dact == 8'hFF) || (m_pwm() < m_dact);
        if (m_ctrl[0]) e = (m_led & {8{on_m & m_phase()}}) ^ {8{m_ctrl[1]}};
        else           e = m_led ^ {8{m_ctrl[1]}};
        we_m = chipselect && !write_n;
`ifdef LED_PWM_BLINK_EN
        bw_m = we_m && (address == 2'd2);
`else
        bw_m = 1'b0;
`endif
        if (!m_ctrl[0]) begin
          m_k = 0; m_w = 0; m_dact = m_duty;
        end else begin
          wrap_m = (m_k % PERIOD) == PERIOD - 1;
          if (wrap_m) m_dact = m_duty;
          m_k++;
          if (bw_m) m_w = 0;
          else if (wrap_m) m_w++;
        end
        if (we_m && address == 2'd0) m_ctrl = writedata[1:0];
        if (we_m && address == 2'd1) m_duty = writedata[7:0];
        if (bw_m) m_blink = writedata[15:0];
        m_led = led_in;
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: compares led_out against the scoreboard once per cycle
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        chk("led_out_in_reset", {24'b0, led_out}, 32'h0);
      end else if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty actual=none expected=entry at %0t", $time);
      end else begin
        chk("led_out", {24'b0, led_out}, {24'b0, exp_q.pop_front()});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a);
    @(negedge clk);
    address = a;
    #1 chk("readdata", readdata, m_read(a));
  endtask

  task automatic count_match(input int n, input logic [7:0] v, output int c);
    c = 0;
    repeat (n) begin
      @(negedge clk);
      if (led_out == v) c++;
    end
  endtask

  logic [31:0] rst_exp [4];
  int cnt;

  initial begin
    rst_exp[0] = 32'h0; rst_exp[1] = 32'hFF; rst_exp[2] = 32'h0; rst_exp[3] = 32'h100;
    idle(3);
    for (int a = 0; a < 4; a++) begin
      @(negedge clk);
      address = 2'(a);
      #1 chk("reset_readdata", readdata, rst_exp[a]);
    end
    @(negedge clk);
    #1 reset_n = 1'b1;
    for (int a = 0; a < 4; a++) rd(2'(a));

    // Passthrough and inversion
    led_in = 8'hA5;
    idle(3);
    chk("passthrough", {24'b0, led_out}, 32'hA5);
    wr(2'd0, 32'h2);
    idle(2);
    chk("invert", {24'b0, led_out}, 32'h5A);

    // 25% duty over two full PWM periods
    wr(2'd1, 32'd64);
    led_in = 8'hFF;
    wr(2'd0, 32'h1);
    idle(1100);
    count_match(2 * PERIOD, 8'hFF, cnt);
    chk("pwm25_on_cycles", 32'(cnt), 32'(PERIOD / 2));
    count_match(2 * PERIOD, 8'h00, cnt);
    chk("pwm25_off_cycles", 32'(cnt), 32'(3 * PERIOD / 2));
    for (int a = 0; a < 4; a++) rd(2'(a));

    // Duty shadowing then duty 0 steady off
    idle(100);
    wr(2'd1, 32'd0);
    idle(PERIOD + 100);
    count_match(PERIOD, 8'h00, cnt);
    chk("duty0_off_cycles", 32'(cnt), 32'(PERIOD));

    // Duty full: follows led_in
    wr(2'd1, 32'hFF);
    idle(PERIOD + 50);
    repeat (300) begin
      @(negedge clk);
      led_in = 8'($urandom);
    end

    // Randomized bus and LED traffic
    repeat (3000) begin
      int r;
      @(negedge clk);
      led_in = 8'($urandom);
      r = $urandom_range(0, 19);
      if (r == 0) begin
        logic [1:0] a;
        a = 2'($urandom_range(0, 3));
        case (a)
          2'd0:    wr(a, 32'($urandom_range(0, 3)));
          2'd2:    wr(a, 32'($urandom_range(0, 3)));
          default: wr(a, $urandom);
        endcase
      end else if (r == 1) begin
        rd(2'($urandom_range(0, 3)));
      end else if (r == 2) begin
        chipselect = 1'b0; write_n = 1'b0;
        address = 2'($urandom_range(0, 3)); writedata = $urandom;
        @(negedge clk);
        write_n = 1'b1;
      end
    end

`ifdef LED_PWM_BLINK_EN
    // Blink gate: alternate 0x0F / 0x00 every two PWM periods
    wr(2'd0, 32'h0);
    wr(2'd2, 32'd2);
    wr(2'd1, 32'hFF);
    led_in = 8'h0F;
    wr(2'd0, 32'h1);
    idle(600);
    count_match(8 * PERIOD, 8'h0F, cnt);
    chk("blink_on_cycles", 32'(cnt), 32'(4 * PERIOD));
    for (int a = 0; a < 4; a++) rd(2'(a));
    idle(700);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1 chk("async_reset_led", {24'b0, led_out}, 32'h0);
    @(negedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    address = 2'd0;
    #1 chk("ctrl_after_reset", readdata, 32'h0);
`else
    wr(2'd2, 32'h5);
    @(negedge clk);
    address = 2'd2;
    #1 chk("blink_absent_read", readdata, 32'h0);
    address = 2'd3;
    #1 chk("status_phase_bit", {31'b0, readdata[8]}, 32'h1);
`endif
    idle(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
